// File: rtl/frv_interrupt_ctrl.sv
// ============================================================================
// Module   : frv_interrupt_ctrl
// Brief    : Machine-mode interrupt controller: NMI, NEXT level/edge external
//            channels, software and timer, fixed priority, registered request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frv_interrupt_ctrl #(
    parameter int              NEXT      = 8,
    parameter logic [NEXT-1:0] EDGE_MASK = {NEXT{1'b0}},
    parameter logic [5:0]      NMI_CAUSE = 6'd63,
    parameter int              IDW       = (NEXT > 1) ? $clog2(NEXT) : 1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            mstatus_mie,
    input  logic            mie_meie,
    input  logic            mie_mtie,
    input  logic            mie_msie,
    input  logic [NEXT-1:0] ex_enable,
    input  logic            nmi_pending,
    input  logic [NEXT-1:0] ex_pending,
    input  logic            ti_pending,
    input  logic            sw_pending,
    output logic            mip_meip,
    output logic            mip_mtip,
    output logic            mip_msip,
    output logic            int_trap_req,
    output logic [5:0]      int_trap_cause,
    input  logic            int_trap_ack,
    output logic [IDW-1:0]  ex_claim_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] c_SRC_NMI = 2'd0;
    localparam logic [1:0] c_SRC_EXT = 2'd1;
    localparam logic [1:0] c_SRC_SW  = 2'd2;
    localparam logic [1:0] c_SRC_TI  = 2'd3;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prev_nmi;
    logic [NEXT-1:0] r_prev_ex;
    logic            r_nmi_lat;
    logic [NEXT-1:0] r_ex_lat;
    logic            r_meip, r_mtip, r_msip;
    logic [5:0]      r_cause;
    logic [1:0]      r_win_src;
    logic [IDW-1:0]  r_win_idx;
    logic [IDW-1:0]  r_claim;

    logic            w_nmi_rise, w_nmi_eff;
    logic [NEXT-1:0] w_ex_rise, w_ex_eff, w_ex_elig;
    logic            w_sw_elig, w_ti_elig;
    logic            w_any, w_ext_found, w_win_live;
    logic [1:0]      w_src;
    logic [IDW-1:0]  w_idx;
    logic [5:0]      w_cause;
    logic            w_grab, w_ack_take, w_nmi_clr;
    logic [NEXT-1:0] w_ex_clr;

    // Edge channels see latch-or-current-edge so a fresh edge is taken the same cycle.
    assign w_nmi_rise = nmi_pending & ~r_prev_nmi;
    assign w_nmi_eff  = r_nmi_lat | w_nmi_rise;
    assign w_ex_rise  = ex_pending & ~r_prev_ex & EDGE_MASK;
    assign w_ex_eff   = (EDGE_MASK & (r_ex_lat | w_ex_rise)) | (~EDGE_MASK & ex_pending);
    assign w_ex_elig  = {NEXT{mstatus_mie & mie_meie}} & ex_enable & w_ex_eff;
    assign w_sw_elig  = mstatus_mie & mie_msie & sw_pending;
    assign w_ti_elig  = mstatus_mie & mie_mtie & ti_pending;

    always_comb begin
        w_any       = 1'b0;
        w_ext_found = 1'b0;
        w_src       = c_SRC_TI;
        w_idx       = '0;
        w_cause     = 6'd0;
        if (w_nmi_eff) begin
            w_any   = 1'b1;
            w_src   = c_SRC_NMI;
            w_cause = NMI_CAUSE;
        end else begin
            for (int i = 0; i < NEXT; i++) begin
                if (!w_ext_found && w_ex_elig[i]) begin
                    w_ext_found = 1'b1;
                    w_idx       = IDW'(i);
                    w_cause     = 6'(16 + i);
                end
            end
            if (w_ext_found) begin
                w_any = 1'b1;
                w_src = c_SRC_EXT;
            end else if (w_sw_elig) begin
                w_any   = 1'b1;
                w_src   = c_SRC_SW;
                w_cause = 6'd3;
            end else if (w_ti_elig) begin
                w_any   = 1'b1;
                w_src   = c_SRC_TI;
                w_cause = 6'd7;
            end
        end
    end

    always_comb begin
        case (r_win_src)
            c_SRC_NMI: w_win_live = 1'b1;
            c_SRC_EXT: w_win_live = w_ex_elig[r_win_idx];
            c_SRC_SW:  w_win_live = w_sw_elig;
            default:   w_win_live = w_ti_elig;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grab      = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_REQ;
                    w_grab      = 1'b1;
                end
            end
            S_REQ: begin
                if (int_trap_ack) begin
                    w_state_nxt = S_GAP;
                    w_ack_take  = 1'b1;
                end else if (!w_win_live) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ex_clr  = '0;
        w_nmi_clr = w_ack_take && (r_win_src == c_SRC_NMI);
        if (w_ack_take && (r_win_src == c_SRC_EXT))
            w_ex_clr[r_win_idx] = 1'b1;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_prev_nmi <= 1'b0;
            r_prev_ex  <= '0;
            r_nmi_lat  <= 1'b0;
            r_ex_lat   <= '0;
            r_meip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_msip     <= 1'b0;
            r_cause    <= 6'd0;
            r_win_src  <= c_SRC_NMI;
            r_win_idx  <= '0;
            r_claim    <= '0;
        end else begin
            r_prev_nmi <= nmi_pending;
            r_prev_ex  <= ex_pending;
            // Set dominates clear: an edge arriving during the ack is kept.
            r_nmi_lat  <= (r_nmi_lat & ~w_nmi_clr) | w_nmi_rise;
            r_ex_lat   <= ((r_ex_lat & ~w_ex_clr) | w_ex_rise) & EDGE_MASK;
            r_meip     <= |(w_ex_eff & ex_enable);
            r_mtip     <= ti_pending;
            r_msip     <= sw_pending;
            if (w_grab) begin
                r_cause   <= w_cause;
                r_win_src <= w_src;
                r_win_idx <= w_idx;
            end
            if (w_ack_take && (r_win_src == c_SRC_EXT))
                r_claim <= r_win_idx;
        end
    end

    assign int_trap_req   = (r_state == S_REQ);
    assign int_trap_cause = r_cause;
    assign ex_claim_id    = r_claim;
    assign mip_meip       = r_meip;
    assign mip_mtip       = r_mtip;
    assign mip_msip       = r_msip;

endmodule

`default_nettype wire

// File: tb/tb_frv_interrupt_ctrl.sv
// ============================================================================
// Module   : tb_frv_interrupt_ctrl
// Brief    : Directed self-checking bench for frv_interrupt_ctrl (NEXT=8, ch3 edge).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frv_interrupt_ctrl;

    localparam int NEXT = 8;
    localparam int IDW  = 3;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic            mstatus_mie, mie_meie, mie_mtie, mie_msie;
    logic [NEXT-1:0] ex_enable;
    logic            nmi_pending;
    logic [NEXT-1:0] ex_pending;
    logic            ti_pending, sw_pending;
    logic            mip_meip, mip_mtip, mip_msip;
    logic            int_trap_req;
    logic [5:0]      int_trap_cause;
    logic            int_trap_ack;
    logic [IDW-1:0]  ex_claim_id;

    int n_tests = 0;
    int n_fail  = 0;

    frv_interrupt_ctrl #(
        .NEXT      (NEXT),
        .EDGE_MASK (8'b0000_1000),
        .NMI_CAUSE (6'd63)
    ) u_dut (
        .g_clk          (g_clk),
        .g_reset        (g_reset),
        .mstatus_mie    (mstatus_mie),
        .mie_meie       (mie_meie),
        .mie_mtie       (mie_mtie),
        .mie_msie       (mie_msie),
        .ex_enable      (ex_enable),
        .nmi_pending    (nmi_pending),
        .ex_pending     (ex_pending),
        .ti_pending     (ti_pending),
        .sw_pending     (sw_pending),
        .mip_meip       (mip_meip),
        .mip_mtip       (mip_mtip),
        .mip_msip       (mip_msip),
        .int_trap_req   (int_trap_req),
        .int_trap_cause (int_trap_cause),
        .int_trap_ack   (int_trap_ack),
        .ex_claim_id    (ex_claim_id)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    initial begin
        g_reset      = 1'b1;
        mstatus_mie  = 1'b0;
        mie_meie     = 1'b0;
        mie_mtie     = 1'b0;
        mie_msie     = 1'b0;
        ex_enable    = '0;
        nmi_pending  = 1'b0;
        ex_pending   = '0;
        ti_pending   = 1'b0;
        sw_pending   = 1'b0;
        int_trap_ack = 1'b0;
        tick(2);
        chk("rst_req",   32'(int_trap_req), 0);
        chk("rst_cause", 32'(int_trap_cause), 0);
        chk("rst_claim", 32'(ex_claim_id), 0);
        chk("rst_mip",   32'({mip_meip, mip_mtip, mip_msip}), 0);
        g_reset = 1'b0;
        tick(2);
        chk("idle_req", 32'(int_trap_req), 0);

        // Priority: level channels 2 and 5 together
        mstatus_mie   = 1'b1;
        mie_meie      = 1'b1;
        ex_enable     = 8'hFF;
        ex_pending[5] = 1'b1;
        ex_pending[2] = 1'b1;
        tick();
        chk("pri_req1",   32'(int_trap_req), 1);
        chk("pri_cause1", 32'(int_trap_cause), 18);
        chk("pri_meip",   32'(mip_meip), 1);
        int_trap_ack = 1'b1;
        tick();
        chk("pri_gap",    32'(int_trap_req), 0);
        chk("pri_claim2", 32'(ex_claim_id), 2);
        int_trap_ack  = 1'b0;
        ex_pending[2] = 1'b0;
        tick();
        chk("pri_idle", 32'(int_trap_req), 0);
        tick();
        chk("pri_req2",   32'(int_trap_req), 1);
        chk("pri_cause2", 32'(int_trap_cause), 21);
        int_trap_ack = 1'b1;
        tick();
        chk("pri_claim5", 32'(ex_claim_id), 5);
        int_trap_ack  = 1'b0;
        ex_pending[5] = 1'b0;
        tick(3);
        chk("pri_quiet", 32'(int_trap_req), 0);

        // Edge latching on channel 3 while globally masked
        mstatus_mie   = 1'b0;
        ex_pending[3] = 1'b1;
        tick();
        ex_pending[3] = 1'b0;
        tick(10);
        chk("edge_masked", 32'(int_trap_req), 0);
        chk("edge_meip",   32'(mip_meip), 1);
        mstatus_mie = 1'b1;
        tick();
        chk("edge_req",   32'(int_trap_req), 1);
        chk("edge_cause", 32'(int_trap_cause), 19);
        int_trap_ack = 1'b1;
        tick();
        chk("edge_claim", 32'(ex_claim_id), 3);
        int_trap_ack = 1'b0;
        tick(5);
        chk("edge_noreq",  32'(int_trap_req), 0);
        chk("edge_meip0",  32'(mip_meip), 0);

        // Withdraw: timer level drops before ack
        mie_mtie   = 1'b1;
        ti_pending = 1'b1;
        tick();
        chk("wd_req",   32'(int_trap_req), 1);
        chk("wd_cause", 32'(int_trap_cause), 7);
        chk("wd_mtip",  32'(mip_mtip), 1);
        ti_pending = 1'b0;
        tick();
        chk("wd_drop",  32'(int_trap_req), 0);
        chk("wd_claim", 32'(ex_claim_id), 3);
        tick(2);
        chk("wd_quiet", 32'(int_trap_req), 0);

        // NMI arrives with mstatus_mie low while timer is in REQ
        ti_pending = 1'b1;
        tick();
        chk("nmi_ti_cause", 32'(int_trap_cause), 7);
        int_trap_ack = 1'b1;
        mstatus_mie  = 1'b0;
        nmi_pending  = 1'b1;
        tick();
        chk("nmi_gap", 32'(int_trap_req), 0);
        int_trap_ack = 1'b0;
        tick();
        chk("nmi_idle", 32'(int_trap_req), 0);
        tick();
        chk("nmi_req",   32'(int_trap_req), 1);
        chk("nmi_cause", 32'(int_trap_cause), 63);
        int_trap_ack = 1'b1;
        tick();
        chk("nmi_claim", 32'(ex_claim_id), 3);
        int_trap_ack = 1'b0;
        nmi_pending  = 1'b0;
        ti_pending   = 1'b0;
        mie_mtie     = 1'b0;
        tick(3);
        chk("nmi_quiet", 32'(int_trap_req), 0);

        // Simultaneous ack + withdraw, with a new edge on the acked channel
        mstatus_mie   = 1'b1;
        ex_pending[3] = 1'b1;
        tick();
        ex_pending[3] = 1'b0;
        tick();
        chk("sim_req",   32'(int_trap_req), 1);
        chk("sim_cause", 32'(int_trap_cause), 19);
        int_trap_ack  = 1'b1;
        ex_enable[3]  = 1'b0;
        ex_pending[3] = 1'b1;
        tick();
        chk("sim_gap", 32'(int_trap_req), 0);
        int_trap_ack  = 1'b0;
        ex_enable[3]  = 1'b1;
        ex_pending[3] = 1'b0;
        tick();
        chk("sim_idle", 32'(int_trap_req), 0);
        tick();
        chk("sim_rereq",  32'(int_trap_req), 1);
        chk("sim_cause2", 32'(int_trap_cause), 19);
        int_trap_ack = 1'b1;
        tick();
        int_trap_ack = 1'b0;
        tick(3);
        chk("sim_quiet", 32'(int_trap_req), 0);

        // Reset mid-REQ, with an edge latched during the request
        mie_msie   = 1'b1;
        sw_pending = 1'b1;
        tick();
        chk("rr_req",   32'(int_trap_req), 1);
        chk("rr_cause", 32'(int_trap_cause), 3);
        ex_pending[3] = 1'b1;
        tick();
        chk("rr_nopre", 32'(int_trap_cause), 3);
        ex_pending[3] = 1'b0;
        g_reset       = 1'b1;
        tick();
        chk("rr_req0",   32'(int_trap_req), 0);
        chk("rr_cause0", 32'(int_trap_cause), 0);
        chk("rr_claim0", 32'(ex_claim_id), 0);
        chk("rr_mip0",   32'({mip_meip, mip_mtip, mip_msip}), 0);
        g_reset = 1'b0;
        tick();
        chk("rr_rel_req",   32'(int_trap_req), 1);
        chk("rr_rel_cause", 32'(int_trap_cause), 3);
        int_trap_ack = 1'b1;
        sw_pending   = 1'b0;
        tick();
        int_trap_ack = 1'b0;
        tick(3);
        chk("rr_quiet", 32'(int_trap_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
